// File: rtl/lsu_pkg.sv
// Shared types and default sizes for the load/store controller.
package lsu_pkg;

  localparam int LSU_AWIDTH  = 32;
  localparam int LSU_ALENGTH = 128;

  // Access size encoding as presented on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_lane.sv
// Lane helper for the load/store controller: little-endian lane extraction
// with sign/zero extension for loads, and byte-enable merge for stores.
// Purely combinational; the word is four byte lanes wide.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int AWIDTH = LSU_AWIDTH
) (
  input  logic [AWIDTH-1:0] i_rd_word,
  input  logic [AWIDTH-1:0] i_old_word,
  input  logic [AWIDTH-1:0] i_wdata,
  input  size_e             i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_signed,
  output logic [AWIDTH-1:0] o_load,
  output logic [AWIDTH-1:0] o_merge
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;
  logic [AWIDTH-1:0] w_src;

  assign w_byte = i_rd_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_rd_word[{i_lane[1], 4'b0000} +: 16];

  // Load result: pick the addressed lane and extend it to a full word.
  always_comb begin
    o_load = i_rd_word;
    case (i_size)
      SZ_BYTE: o_load = {{(AWIDTH-8){i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{(AWIDTH-16){i_signed & w_half[15]}}, w_half};
      default: o_load = i_rd_word;
    endcase
  end

  // Store merge: replicate the store data across lanes and enable only the addressed ones.
  always_comb begin
    w_be  = 4'b0000;
    w_src = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_be  = 4'b0001 << i_lane;
        w_src = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be  = i_lane[1] ? 4'b1100 : 4'b0011;
        w_src = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be  = 4'b1111;
        w_src = i_wdata;
      end
      default: begin
        w_be  = 4'b0000;
        w_src = i_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign o_merge[gi*8 +: 8] = w_be[gi] ? w_src[gi*8 +: 8] : i_old_word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time from execute, word-indexed
// data memory access with read-modify-write for sub-word stores, and a
// held response to writeback.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses are rejected; otherwise they are silently aligned.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AWIDTH  = LSU_AWIDTH,
  parameter int ALENGTH = LSU_ALENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [AWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [AWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [AWIDTH-1:0] mem_wdata,
  input  logic [AWIDTH-1:0] mem_rdata
);

  localparam logic [AWIDTH-1:0] LIMIT = AWIDTH'(ALENGTH);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_we;
  size_e             r_size;
  logic              r_signed;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH-1:0] r_wdata;
  logic [AWIDTH-1:0] r_old;
  logic [AWIDTH-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  size_e             w_size;
  logic [AWIDTH-1:0] w_index;
  logic [AWIDTH-1:0] w_addr_adj;
  logic              w_misalign;
  logic              w_req_err;
  logic [AWIDTH-1:0] w_load;
  logic [AWIDTH-1:0] w_merge;

  assign w_accept = req_valid && (r_state == IDLE) && !rst;
  assign w_size   = size_e'(req_size);
  assign w_index  = {2'b00, req_addr[AWIDTH-1:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_HALF) && req_addr[0]) ||
                      ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_addr_adj = req_addr;
`else
  assign w_misalign = 1'b0;
  // Drop the offending low address bits so the access proceeds aligned.
  always_comb begin
    w_addr_adj = req_addr;
    if (w_size == SZ_HALF) begin
      w_addr_adj[0] = 1'b0;
    end else if (w_size == SZ_WORD) begin
      w_addr_adj[1:0] = 2'b00;
    end
  end
`endif

  // Word 0 is hardwired zero, so stores there are rejected like out-of-range accesses.
  assign w_req_err = (w_index >= LIMIT) || (w_size == SZ_RSVD) ||
                     (req_we && (w_index == '0)) || w_misalign;

  lsu_lane #(
    .AWIDTH(AWIDTH)
  ) u_lane (
    .i_rd_word (mem_rdata),
    .i_old_word(r_old),
    .i_wdata   (r_wdata),
    .i_size    (r_size),
    .i_lane    (r_addr[1:0]),
    .i_signed  (r_signed),
    .o_load    (w_load),
    .o_merge   (w_merge)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture on acceptance, and memory word capture in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= w_size;
      r_signed <= req_signed;
      r_addr   <= w_addr_adj;
      r_wdata  <= req_wdata;
      r_old    <= '0;
      r_rdata  <= '0;
      r_err    <= w_req_err;
    end else if (r_state == READ) begin
      if (r_we) begin
        r_old <= mem_rdata;
      end else begin
        r_rdata <= w_load;
      end
    end
  end

  // Next-state and output decode; reset masks every output so nothing leaks mid-abort.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_err) begin
            w_state_next = RESP;
          end else if (req_we && (w_size == SZ_WORD)) begin
            w_state_next = WRITE;
          end else begin
            w_state_next = READ;
          end
        end
      end
      READ: begin
        mem_addr     = {2'b00, r_addr[AWIDTH-1:2]};
        w_state_next = r_we ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr     = {2'b00, r_addr[AWIDTH-1:2]};
        mem_we       = 1'b1;
        mem_wdata    = w_merge;
        w_state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes hand-computed expected
// responses, a negedge monitor pops and compares them, including latency.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.AWIDTH(32), .ALENGTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model with a bench-side preload port.
  logic [31:0] mem [0:127];
  logic        pre_we = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[6:0]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int we_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic in_resp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: write observer and response scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp got rdata=%h err=%b required no response", resp_rdata, resp_err);
      end else begin
        if (!in_resp) begin
          chk("latency", cyc, sb[0].due);
          in_resp = 1'b1;
        end
        chk("resp_rdata", resp_rdata, sb[0].rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, sb[0].err});
        if (resp_ready) begin
          $display("resp: cyc=%0d rdata=%h err=%b", cyc, resp_rdata, resp_err);
          void'(sb.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, output int acc);
    exp_t e;
    int n;
    logic ok;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_signed = sg;
    req_addr = addr;
    req_wdata = wdata;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      n++;
    end
    acc = -1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got req_ready=0 required 1 for addr=%h", addr);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
      e.rdata = exp_rd;
      e.err = exp_err;
      e.due = acc + lat - 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL resp_timeout got pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int a1, a2, wc0, n;

  initial begin
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h10;
    req_wdata = 32'h1;
    resp_ready = 1'b1;
    preload(7'd4, 32'h0);
    preload(7'd6, 32'hCAFEF00D);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word store then back-to-back word load.
    wc0 = we_count;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, a2);
    chk("thru_word", a2 - a1, 32'd3);
    wait_idle();
    chk("word_we_pulses", we_count - wc0, 32'd1);
    chk("word_waddr", last_waddr, 32'd4);
    chk("word_wdata", last_wdata, 32'hDEADBEEF);

    // Byte store as read-modify-write, then byte loads.
    preload(7'd4, 32'h11223344);
    preload(7'd5, 32'h55667788);
    wc0 = we_count;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 32'h0, 1'b0, 3, a1);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 2, a2);
    chk("thru_subword", a2 - a1, 32'd4);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000AA, 1'b0, 2, a1);
    wait_idle();
    chk("byte_we_pulses", we_count - wc0, 32'd1);
    chk("byte_waddr", last_waddr, 32'd4);
    chk("byte_wdata", last_wdata, 32'h11AA3344);

    // Halfword store into the upper lane, then halfword and byte loads.
    wc0 = we_count;
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, 32'h0, 1'b0, 3, a1);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'hFFFFBEEF, 1'b0, 2, a1);
    issue(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'h00007788, 1'b0, 2, a1);
    issue(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'hFFFFFF88, 1'b0, 2, a1);
    wait_idle();
    chk("half_wdata", last_wdata, 32'hBEEF7788);
    chk("half_we_pulses", we_count - wc0, 32'd1);

    // Rejected requests: store to word 0, out of range, reserved size.
    wc0 = we_count;
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, 32'h0, 1'b1, 1, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1, a1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, a1);
    issue(1'b1, 2'b00, 1'b0, 32'h3, 32'h55, 32'h0, 1'b1, 1, a1);
    wait_idle();
    chk("err_no_write", we_count - wc0, 32'd0);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, a1);
`else
    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h000011AA, 1'b0, 2, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h11AA3344, 1'b0, 2, a1);
`endif
    wait_idle();

    // Backpressure: response held for 5 cycles.
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 2, a1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released", {31'b0, resp_valid}, 32'd0);
    chk("bp_popped", sb.size(), 32'd0);
    @(posedge clk);
    #1;

    // Reset during a word store's WRITE cycle.
    wc0 = we_count;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h18;
    req_wdata = 32'h12345678;
    @(negedge clk);
    chk("rw_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("rw_mem_kept", mem[6], 32'hCAFEF00D);
    chk("rw_no_write", we_count - wc0, 32'd0);
    @(posedge clk);
    #1;

    // Recovery after the aborted store.
    issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2, a1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
